// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order single-outstanding memory reads and
// buffers up to two {pc, instr} responses for decode; redirects flush everything.
module fetch_stage #(
  parameter int              W        = 32,
  parameter logic [W-1:0]    RESET_PC = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         redirect_i,
  input  logic [W-1:0] redirect_pc_i,
  output logic         imem_req_o,
  output logic [W-1:0] imem_addr_o,
  input  logic         imem_gnt_i,
  input  logic         imem_rvalid_i,
  input  logic [W-1:0] imem_rdata_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] instr_o
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_pc_q;
  logic [W-1:0] r_req_pc;
  logic [W-1:0] r_fifo_pc    [2];
  logic [W-1:0] r_fifo_instr [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  logic         w_req;
  logic         w_issue;
  logic         w_push;
  logic         w_pop;
  logic [W-1:0] w_redir_pc;

  // Issuing only while count<2 reserves the FIFO slot for the response.
  assign w_req      = !rst_i && (r_state == ST_REQ) && (r_count != 2'd2) && !redirect_i;
  assign w_issue    = w_req && imem_gnt_i;
  assign w_push     = (r_state == ST_WAIT) && imem_rvalid_i && !redirect_i;
  assign w_pop      = (r_count != 2'd0) && ready_i && !redirect_i;
  assign w_redir_pc = {redirect_pc_i[W-1:2], 2'b00};

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc_q;
  assign valid_o     = (r_count != 2'd0);
  assign pc_o        = valid_o ? r_fifo_pc[r_rd_ptr]    : '0;
  assign instr_o     = valid_o ? r_fifo_instr[r_rd_ptr] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_REQ;
      r_pc_q   <= RESET_PC;
      r_req_pc <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
    end else begin
      if (redirect_i) begin
        r_pc_q   <= w_redir_pc;
        r_count  <= 2'd0;
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
      end else begin
        if (w_issue) begin
          r_req_pc <= r_pc_q;
          r_pc_q   <= r_pc_q + W'(4);
        end
        if (w_push) begin
          r_fifo_pc[r_wr_ptr]    <= r_req_pc;
          r_fifo_instr[r_wr_ptr] <= imem_rdata_i;
          r_wr_ptr               <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end

      // A redirect while a response is outstanding turns it into a discard.
      case (r_state)
        ST_REQ:  if (w_issue) r_state <= ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid_i)   r_state <= ST_REQ;
          else if (redirect_i) r_state <= ST_DROP;
        end
        ST_DROP: if (imem_rvalid_i) r_state <= ST_REQ;
        default: r_state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a memory/redirect model predicts
// the delivered {pc, instr} stream and the request/address behaviour.
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;

  fetch_stage #(.W(32), .RESET_PC(RPC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o)
  );

  always #5 clk_i = ~clk_i;

  ent_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] model_pc = RPC;
  bit          outstanding = 0;
  logic [31:0] out_addr = '0;
  int          out_epoch = 0;
  int          epoch = 0;
  int          delay = 0;
  bit          pend_flush = 0;
  bit          pend_push = 0;
  ent_t        pend_e;

  int          p_gnt = 100, p_ready = 100, p_redir = 0, max_delay = 0;
  int          redir_mode = 0;
  logic [31:0] force_tgt = '0;
  bit          redir_hit = 0;
  bit          rst_on_wait1 = 0;
  bit          rst_hit = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  task automatic step(input bit rst_in);
    bit          rst;
    bit          redir;
    bit          exp_req;
    logic [31:0] tgt;
    @(posedge clk_i); #1;
    if (pend_flush) sb.delete();
    if (pend_push)  sb.push_back(pend_e);
    pend_flush = 0;
    pend_push  = 0;
    rst = rst_in;
    if (rst_on_wait1 && outstanding && sb.size() == 1) begin
      rst = 1;
      rst_on_wait1 = 0;
      rst_hit = 1;
    end
    if (rst) begin
      sb.delete();
      outstanding = 0;
      model_pc = RPC;
      epoch++;
    end
    rst_i      = rst;
    imem_gnt_i = ($urandom_range(0, 99) < p_gnt);
    ready_i    = ($urandom_range(0, 99) < p_ready);
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (outstanding) begin
      if (delay == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(out_addr);
      end else delay--;
    end
    redir = 0;
    tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                      : ($urandom & 32'h0000_FFFF);
    if (!rst) begin
      case (redir_mode)
        1: if (outstanding && !imem_rvalid_i) begin redir = 1; tgt = force_tgt; end
        2: if (imem_rvalid_i && sb.size() != 0) begin redir = 1; tgt = force_tgt; end
        3: begin redir = 1; tgt = force_tgt; end
        default: redir = ($urandom_range(0, 99) < p_redir);
      endcase
      if (redir && redir_mode != 0) begin
        redir_mode = 0;
        redir_hit = 1;
      end
    end
    redirect_i    = redir;
    redirect_pc_i = tgt;
    if (rst) begin
      #1;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      #4;
    end else #5;
    // Sample point, mid-low phase of the clock.
    exp_req = !rst && !redir && !outstanding && (sb.size() < 2);
    chk("req", 32'(imem_req_o), 32'(exp_req));
    if (!rst) chk("addr", imem_addr_o, model_pc);
    if (imem_rvalid_i) begin
      outstanding = 0;
      if (out_epoch == epoch && !redir && !rst) begin
        pend_push = 1;
        pend_e = '{out_addr, mem_word(out_addr)};
      end
    end
    if (!rst) begin
      if (redir) begin
        pend_flush = 1;
        model_pc = tgt & 32'hFFFF_FFFC;
        epoch++;
      end else if (imem_req_o && imem_gnt_i) begin
        outstanding = 1;
        out_addr = model_pc;
        out_epoch = epoch;
        delay = $urandom_range(0, max_delay);
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  task automatic run_until_redir(input string name, input int mode, input logic [31:0] t);
    redir_mode = mode;
    force_tgt = t;
    redir_hit = 0;
    for (int i = 0; i < 300 && !redir_hit; i++) step(0);
    chk(name, 32'(redir_hit), 32'd1);
    redir_mode = 0;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk_i); #7;
      chk("valid", 32'(valid_o), 32'(sb.size() != 0));
      if (!valid_o) begin
        chk("idle_pc", pc_o, 32'd0);
        chk("idle_instr", instr_o, 32'd0);
      end else if (sb.size() != 0) begin
        chk("head_pc", pc_o, sb[0].pc);
        chk("head_instr", instr_o, sb[0].instr);
        if (ready_i && !redirect_i) void'(sb.pop_front());
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 3; i++) step(1);
    // Free-flowing fetch, fixed 1-cycle response latency.
    p_gnt = 100; p_ready = 100; p_redir = 0; max_delay = 0;
    run(20);
    // Decode stalled: FIFO fills, requests stop, then resume.
    p_ready = 0;
    run(12);
    p_ready = 100;
    run(10);
    // Redirect while a response is pending.
    max_delay = 2;
    run_until_redir("redir_wait_hit", 1, 32'h0000_0100);
    run(15);
    // Redirect coincident with a response and a non-empty FIFO.
    max_delay = 0; p_ready = 50;
    run_until_redir("redir_rvalid_hit", 2, 32'h0000_0203);
    run(15);
    // Grant withheld, then address wrap at the top of memory.
    p_gnt = 0; p_ready = 100;
    run(4);
    run_until_redir("redir_wrap_hit", 3, 32'hFFFF_FFF8);
    p_gnt = 100;
    run(12);
    // Randomized traffic.
    p_gnt = 60; p_ready = 70; p_redir = 4; max_delay = 3;
    run(3000);
    // Reset while waiting with one buffered entry.
    p_redir = 0; p_gnt = 100; p_ready = 30; max_delay = 3;
    rst_on_wait1 = 1;
    rst_hit = 0;
    for (int i = 0; i < 300 && !rst_hit; i++) step(0);
    chk("rst_wait1_hit", 32'(rst_hit), 32'd1);
    rst_on_wait1 = 0;
    step(1);
    step(1);
    p_ready = 100;
    run(20);
    p_gnt = 60; p_ready = 70; p_redir = 4;
    run(300);
    @(posedge clk_i); #8;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
